// File: rtl/dense_pkg.sv
// Shared definitions for the dense layer: state encoding, accumulator sizing
// and the shift-and-saturate rule that the conv layers also use.
package dense_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WRITE, DONE} state_t;

  function automatic int acc_width(input int s1, input int sw, input int n_in, input int shift);
    return s1 + sw + $clog2(n_in + 1) + shift;
  endfunction

  // Arithmetic shift (floor) then clamp to a signed out_w-bit range.
  function automatic logic signed [31:0] sat_shift(input logic signed [63:0] acc,
                                                   input int shift, input int out_w);
    logic signed [63:0] sh, hi, lo;
    sh = acc >>> shift;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (sh > hi) sh = hi;
    else if (sh < lo) sh = lo;
    return sh[31:0];
  endfunction
endpackage

// File: rtl/dense_sat.sv
// Combinational rescale of the neuron accumulator to a saturated score word.
module dense_sat import dense_pkg::*; #(
  parameter int ACC_W = 33,
  parameter int OUT_W = 11,
  parameter int SHIFT = 8
) (
  input  logic [ACC_W-1:0] acc,
  output logic [OUT_W-1:0] score
);
  logic signed [63:0] wide;

  assign wide  = {{(64-ACC_W){acc[ACC_W-1]}}, acc};
  assign score = OUT_W'(sat_shift(wide, SHIFT, OUT_W));
endmodule

// File: rtl/dense.sv
// Fully-connected output layer: streams activations and weights, accumulates
// one neuron at a time behind a 2-deep read pipeline, writes saturated scores.
module dense import dense_pkg::*; #(
  parameter int SIZE_1           = 11,
  parameter int SIZE_W           = 9,
  parameter int N_IN             = 16,
  parameter int N_OUT            = 10,
  parameter int SHIFT            = 8,
  parameter int SIZE_address_pix = 13,
  parameter int SIZE_address_wei = 13
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic [SIZE_address_pix-1:0] memstartp,
  input  logic [SIZE_address_wei-1:0] memstartw,
  input  logic [SIZE_address_pix-1:0] memstartzap,
  output logic [SIZE_address_pix-1:0] read_addressp,
  input  logic [SIZE_1-1:0]           qp,
  output logic                        re_p,
  output logic [SIZE_address_wei-1:0] read_addressw,
  input  logic [SIZE_W-1:0]           qw,
  output logic                        re_w,
  output logic [SIZE_address_pix-1:0] write_addressp,
  output logic [SIZE_1-1:0]           dp,
  output logic                        we,
  output logic                        STOP
);
  localparam int ACC_W  = acc_width(SIZE_1, SIZE_W, N_IN, SHIFT);
  localparam int CW     = $clog2(N_IN + 1);
  localparam int JW     = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int STAGES = 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N_IN);
  localparam logic [JW-1:0] J_LAST   = JW'(N_OUT - 1);

  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [JW-1:0] j, j_nx;
  logic [SIZE_address_wei-1:0] wbase;
  logic [STAGES:0] vld_pipe, bias_pipe;
  logic issue;
  logic signed [ACC_W-1:0] acc, prod_t, bias_t;
  logic signed [SIZE_1+SIZE_W-1:0] prod;
  logic [SIZE_1-1:0] score;

  assign issue  = enable && (state == ISSUE);
  assign prod   = $signed(qp) * $signed(qw);
  assign prod_t = ACC_W'(prod);
  assign bias_t = ACC_W'($signed(qw)) <<< SHIFT;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      j     <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      j     <= j_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    j_nx     = j;
    if (!enable) begin
      state_nx = IDLE;
      cnt_nx   = '0;
      j_nx     = '0;
    end else begin
      case (state)
        IDLE: if (!STOP) begin
          state_nx = ISSUE;
          cnt_nx   = '0;
          j_nx     = '0;
        end
        ISSUE: if (cnt == CNT_LAST) begin
          state_nx = DRAIN;
          cnt_nx   = '0;
        end else cnt_nx = cnt + 1'b1;
        DRAIN: if (cnt == CW'(1)) begin
          state_nx = WRITE;
          cnt_nx   = '0;
        end else cnt_nx = cnt + 1'b1;
        WRITE: if (j == J_LAST) state_nx = DONE;
          else begin
            state_nx = ISSUE;
            j_nx     = j + 1'b1;
          end
        DONE: state_nx = DONE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Memory ports are registered off the current state, so each address sits
  // one cycle behind the FSM and its data lands two edges later.
  always_ff @(posedge clk) begin
    if (rst) begin
      read_addressp  <= '0;
      read_addressw  <= '0;
      write_addressp <= '0;
      dp             <= '0;
      re_p           <= 1'b0;
      re_w           <= 1'b0;
      we             <= 1'b0;
      STOP           <= 1'b0;
      wbase          <= '0;
      acc            <= '0;
      vld_pipe       <= '0;
      bias_pipe      <= '0;
    end else begin
      re_p      <= 1'b0;
      re_w      <= 1'b0;
      we        <= 1'b0;
      STOP      <= enable && (state == DONE);
      vld_pipe  <= enable ? {vld_pipe[STAGES-1:0], issue} : '0;
      bias_pipe <= {bias_pipe[STAGES-1:0], cnt == CNT_LAST};
      if (issue) begin
        read_addressp <= memstartp + SIZE_address_pix'(cnt);
        read_addressw <= wbase + SIZE_address_wei'(cnt);
        re_p          <= (cnt != CNT_LAST);
        re_w          <= 1'b1;
      end
      if (state == IDLE) begin
        acc   <= '0;
        wbase <= memstartw;
      end else if (state == WRITE) begin
        acc   <= '0;
        wbase <= wbase + SIZE_address_wei'(N_IN + 1);
        if (enable) begin
          we             <= 1'b1;
          dp             <= score;
          write_addressp <= memstartzap + SIZE_address_pix'(j);
        end
      end else if (vld_pipe[STAGES]) begin
        acc <= acc + (bias_pipe[STAGES] ? bias_t : prod_t);
      end
    end
  end

  dense_sat #(.ACC_W(ACC_W), .OUT_W(SIZE_1), .SHIFT(SHIFT)) u_sat (
    .acc  (acc),
    .score(score)
  );
endmodule

// File: tb/tb_dense.sv
// Bench for dense: memory models around the DUT, a per-neuron arithmetic
// reference, and scenario tasks for patterns, abort, reset and restart.
module tb_dense;
  localparam int NI = 16;
  localparam int NO = 10;
  localparam int PASS_EDGES = NO * (NI + 4) + 1;
  localparam logic [10:0] SENT = 11'h555;

  logic clk = 1'b0;
  logic rst, enable, clr;
  logic [12:0] memstartp, memstartw, memstartzap, read_addressp, read_addressw, write_addressp;
  logic [10:0] qp, dp;
  logic [8:0]  qw;
  logic re_p, re_w, we, STOP;
  logic [10:0] pmem [0:8191];
  logic [8:0]  wmem [0:8191];
  logic [10:0] smem [0:8191];
  int x [NI];
  int w [NO][NI+1];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dense dut (
    .clk(clk), .rst(rst), .enable(enable),
    .memstartp(memstartp), .memstartw(memstartw), .memstartzap(memstartzap),
    .read_addressp(read_addressp), .qp(qp), .re_p(re_p),
    .read_addressw(read_addressw), .qw(qw), .re_w(re_w),
    .write_addressp(write_addressp), .dp(dp), .we(we), .STOP(STOP)
  );

  always @(posedge clk) begin
    qp <= pmem[read_addressp];
    qw <= wmem[read_addressw];
  end

  always @(posedge clk) begin
    if (clr) for (int k = 0; k < 8192; k++) smem[k] <= SENT;
    else if (we) smem[write_addressp] <= dp;
  end

  function automatic int ref_score(input int j);
    longint acc;
    acc = 0;
    for (int i = 0; i < NI; i++) acc += longint'(x[i]) * longint'(w[j][i]);
    acc += longint'(w[j][NI]) * 256;
    acc = acc >>> 8;
    if (acc > 1023) return 1023;
    if (acc < -1024) return -1024;
    return int'(acc);
  endfunction

  task automatic load(input int mp, input int mw, input int mz);
    enable = 1'b0;
    memstartp = 13'(mp);
    memstartw = 13'(mw);
    memstartzap = 13'(mz);
    for (int i = 0; i < NI; i++) pmem[mp+i] = 11'(x[i]);
    for (int j = 0; j < NO; j++)
      for (int i = 0; i <= NI; i++) wmem[mw + j*(NI+1) + i] = 9'(w[j][i]);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  task automatic do_pass(input string name, input int mp, input int mw, input int mz);
    int n, nwe, last, nrp, nrw, exp, got;
    bit done;
    n = 0; nwe = 0; last = -1; nrp = 0; nrw = 0; done = 0;
    enable = 1'b1;
    while (!done && n < 400) begin
      @(posedge clk); #1; n++;
      if (re_p) nrp++;
      if (re_w) nrw++;
      if (n == 2) begin
        tests++;
        if (read_addressp !== 13'(mp) || read_addressw !== 13'(mw) || re_p !== 1'b1 || re_w !== 1'b1) begin
          fails++;
          $display("FAIL %s first_addr: got p=%0d w=%0d re_p=%b re_w=%b want p=%0d w=%0d re=1/1",
                   name, read_addressp, read_addressw, re_p, re_w, mp, mw);
        end
      end
      if (n == 18) begin
        tests++;
        if (read_addressw !== 13'(mw + NI) || re_p !== 1'b0 || re_w !== 1'b1) begin
          fails++;
          $display("FAIL %s bias_addr: got w=%0d re_p=%b re_w=%b want w=%0d re_p=0 re_w=1",
                   name, read_addressw, re_p, re_w, mw + NI);
        end
      end
      if (we === 1'b1) begin
        exp = (nwe < NO) ? ref_score(nwe) : 0;
        got = int'($signed(dp));
        tests++;
        if (nwe >= NO || write_addressp !== 13'(mz + nwe) || got != exp || (last >= 0 && n - last != NI + 4)) begin
          fails++;
          $display("FAIL %s write%0d: got addr=%0d dp=%0d gap=%0d want addr=%0d dp=%0d gap=%0d",
                   name, nwe, write_addressp, got, n - last, mz + nwe, exp, NI + 4);
        end
        last = n;
        nwe++;
      end
      if (STOP === 1'b1) done = 1;
    end
    tests++;
    if (!done || n - 1 != PASS_EDGES) begin
      fails++;
      $display("FAIL %s stop_edge: got %0d (seen=%0d) want %0d", name, n - 1, done, PASS_EDGES);
    end
    tests++;
    if (nwe != NO || nrp != NO*NI || nrw != NO*(NI+1)) begin
      fails++;
      $display("FAIL %s strobe_counts: got we=%0d re_p=%0d re_w=%0d want %0d %0d %0d",
               name, nwe, nrp, nrw, NO, NO*NI, NO*(NI+1));
    end
    for (int j = 0; j < NO; j++) begin
      got = int'($signed(smem[mz+j]));
      exp = ref_score(j);
      tests++;
      if (smem[mz+j] === SENT || got != exp) begin
        fails++;
        $display("FAIL %s score%0d: got %0d want %0d", name, j, got, exp);
      end
    end
  endtask

  task automatic set_pattern(input int xv, input int wbase_v, input int wstep, input int bbase, input int bstep);
    for (int i = 0; i < NI; i++) x[i] = xv;
    for (int j = 0; j < NO; j++) begin
      for (int i = 0; i < NI; i++) w[j][i] = wbase_v + wstep * j;
      w[j][NI] = bbase + bstep * j;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; clr = 1'b0;
    memstartp = '0; memstartw = '0; memstartzap = '0;
    repeat (3) @(posedge clk);
    enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({read_addressp, read_addressw, write_addressp, dp, re_p, re_w, we, STOP} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got ra_p=%0d ra_w=%0d wa=%0d dp=%0d re=%b%b we=%b stop=%b want all 0",
               read_addressp, read_addressw, write_addressp, dp, re_p, re_w, we, STOP);
    end
    rst = 1'b0; enable = 1'b0;
  endtask

  task automatic test_ramp();
    set_pattern(256, 0, 1, 0, 0);
    load(100, 1000, 4000);
    do_pass("ramp", 100, 1000, 4000);
  endtask

  task automatic test_saturate();
    set_pattern(1023, 255, 0, 0, 0);
    load(200, 2000, 4100);
    do_pass("sat_pos", 200, 2000, 4100);
    set_pattern(1023, -256, 0, 0, 0);
    load(300, 2500, 4200);
    do_pass("sat_neg", 300, 2500, 4200);
  endtask

  task automatic test_bias();
    set_pattern(0, 7, 3, -5, 1);
    load(50, 3000, 4300);
    do_pass("bias", 50, 3000, 4300);
  endtask

  task automatic test_random();
    int mp, mw, mz;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < NI; i++)
        x[i] = (p == 0) ? $urandom_range(0, 127) - 64 : $urandom_range(0, 2047) - 1024;
      for (int j = 0; j < NO; j++)
        for (int i = 0; i <= NI; i++)
          w[j][i] = (p == 0) ? $urandom_range(0, 63) - 32 : $urandom_range(0, 511) - 256;
      mp = $urandom_range(0, 1000);
      mw = $urandom_range(2000, 3500);
      mz = $urandom_range(5000, 6000);
      load(mp, mw, mz);
      do_pass("random", mp, mw, mz);
    end
  endtask

  task automatic test_abort();
    bit bad;
    int got, exp;
    bad = 0;
    set_pattern(256, 0, 1, 0, 0);
    load(100, 1000, 4000);
    enable = 1'b1;
    repeat (65) @(posedge clk);
    #1;
    tests++;
    if (re_w !== 1'b1) begin
      fails++;
      $display("FAIL abort_in_issue: got re_w=%b want 1", re_w);
    end
    enable = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (we !== 1'b0 || re_p !== 1'b0 || re_w !== 1'b0 || STOP !== 1'b0) bad = 1;
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL abort_quiet: got strobe activity after abort want none");
    end
    for (int j = 0; j < NO; j++) begin
      got = int'($signed(smem[4000+j]));
      exp = (j < 3) ? ref_score(j) : int'($signed(SENT));
      tests++;
      if (smem[4000+j] !== ((j < 3) ? 11'(exp) : SENT)) begin
        fails++;
        $display("FAIL abort_mem%0d: got %0d want %0d", j, got, exp);
      end
    end
    load(100, 1000, 4000);
    do_pass("abort_rerun", 100, 1000, 4000);
  endtask

  task automatic test_reset_mid();
    set_pattern(256, -3, 2, 4, -1);
    load(400, 1500, 4500);
    enable = 1'b1;
    repeat (18) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    tests++;
    if ({read_addressp, read_addressw, write_addressp, dp, re_p, re_w, we, STOP} !== '0) begin
      fails++;
      $display("FAIL reset_mid: got ra_p=%0d ra_w=%0d re=%b%b we=%b stop=%b want all 0",
               read_addressp, read_addressw, re_p, re_w, we, STOP);
    end
    rst = 1'b0;
    do_pass("after_reset", 400, 1500, 4500);
  endtask

  task automatic test_hold_stop();
    bit bad;
    bad = 0;
    set_pattern(100, 5, -1, 2, 3);
    load(600, 3300, 4700);
    do_pass("hold_first", 600, 3300, 4700);
    repeat (30) begin
      @(posedge clk); #1;
      if (STOP !== 1'b1 || re_p !== 1'b0 || re_w !== 1'b0 || we !== 1'b0) bad = 1;
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL hold_stop: got activity or STOP drop while enable held want STOP=1 quiet");
    end
    enable = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (STOP !== 1'b0) begin
      fails++;
      $display("FAIL stop_clear: got %b want 0", STOP);
    end
    load(600, 3300, 4700);
    do_pass("hold_second", 600, 3300, 4700);
  endtask

  initial begin
    for (int k = 0; k < 8192; k++) begin
      pmem[k] = '0;
      wmem[k] = '0;
    end
    test_reset();
    test_ramp();
    test_saturate();
    test_bias();
    test_random();
    test_abort();
    test_reset_mid();
    test_hold_stop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
